// File: rtl/pipeline_scoreboard_if.sv
// Decode <-> scoreboard bundle for the in-order pipeline.
//   master : decode side, drives the decoded instruction fields and flush,
//            receives stall/issue/forwarding and the in-flight status view.
//   slave  : the scoreboard itself.
// Signals:
//   dec_valid, dec_rx/dec_ry (+_rd), dec_wr_en/dec_wr_reg, dec_flag_rd/_wr,
//   dec_mem_rd/_wr, flush                      -> decode to scoreboard
//   stall, issue, fwd_rx, fwd_ry, pending_regs,
//   inflight_count, stall_count                -> scoreboard to decode
interface pipeline_scoreboard_if #(
  parameter int NUM_REGS = 8,
  parameter int WB_LAT   = 2,
  parameter int CNT_W    = 16
);
  localparam int REG_W = $clog2(NUM_REGS);
  localparam int INF_W = $clog2(WB_LAT + 1);

  logic             dec_valid;
  logic [REG_W-1:0] dec_rx;
  logic [REG_W-1:0] dec_ry;
  logic             dec_rx_rd;
  logic             dec_ry_rd;
  logic             dec_wr_en;
  logic [REG_W-1:0] dec_wr_reg;
  logic             dec_flag_rd;
  logic             dec_flag_wr;
  logic             dec_mem_rd;
  logic             dec_mem_wr;
  logic             flush;

  logic                stall;
  logic                issue;
  logic                fwd_rx;
  logic                fwd_ry;
  logic [NUM_REGS-1:0] pending_regs;
  logic [INF_W-1:0]    inflight_count;
  logic [CNT_W-1:0]    stall_count;

  modport master (
    output dec_valid, dec_rx, dec_ry, dec_rx_rd, dec_ry_rd, dec_wr_en,
           dec_wr_reg, dec_flag_rd, dec_flag_wr, dec_mem_rd, dec_mem_wr, flush,
    input  stall, issue, fwd_rx, fwd_ry, pending_regs, inflight_count,
           stall_count
  );

  modport slave (
    input  dec_valid, dec_rx, dec_ry, dec_rx_rd, dec_ry_rd, dec_wr_en,
           dec_wr_reg, dec_flag_rd, dec_flag_wr, dec_mem_rd, dec_mem_wr, flush,
    output stall, issue, fwd_rx, fwd_ry, pending_regs, inflight_count,
           stall_count
  );
endinterface

// File: rtl/pipeline_scoreboard.sv
// Hazard scoreboard between decode and execute of the in-order pipeline.
// Every issued instruction is tracked in a WB_LAT-deep shift register until
// writeback; decode is stalled on RAW hazards against registers, the NZ flags
// and memory (load after store). Flush squashes the younger in-flight work.
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-high
//   sb     pipeline_scoreboard_if.slave (decode fields in, stall/issue/status out)
//
// Optional feature: define SCOREBOARD_FORWARDING_EN to let a source register
// produced by the entry currently in writeback be taken from the writeback bus
// (fwd_rx/fwd_ry) instead of stalling.
module pipeline_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int WB_LAT   = 2,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_scoreboard_if.slave sb
);
  localparam int REG_W = $clog2(NUM_REGS);
  localparam int INF_W = $clog2(WB_LAT + 1);
  // One-hot marker of the writeback position (WB_LAT-1).
  localparam logic [WB_LAT-1:0] WB_MASK = WB_LAT'(1) << (WB_LAT - 1);

  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic [REG_W-1:0] wr_reg;
    logic             flag_wr;
    logic             mem_wr;
  } entry_t;

  entry_t q [WB_LAT];

  logic [WB_LAT-1:0]   rx_hit, ry_hit, flag_hit, mem_hit;
  logic [NUM_REGS-1:0] pend;
  logic [INF_W-1:0]    inflight;
  logic                rx_hz, ry_hz, stall_w, issue_w;
  logic [CNT_W-1:0]    stall_cnt;

  // NOTE: every signal written here gets a default first so no latch is
  // inferred when the loop or a condition leaves it untouched.
  always_comb begin
    rx_hit   = '0;
    ry_hit   = '0;
    flag_hit = '0;
    mem_hit  = '0;
    pend     = '0;
    inflight = '0;
    for (int i = 0; i < WB_LAT; i++) begin
      if (q[i].valid) begin
        inflight    = inflight + INF_W'(1);
        rx_hit[i]   = q[i].wr_en & sb.dec_rx_rd & (q[i].wr_reg == sb.dec_rx);
        ry_hit[i]   = q[i].wr_en & sb.dec_ry_rd & (q[i].wr_reg == sb.dec_ry);
        flag_hit[i] = q[i].flag_wr & sb.dec_flag_rd;
        mem_hit[i]  = q[i].mem_wr & sb.dec_mem_rd;
        if (q[i].wr_en) pend[q[i].wr_reg] = 1'b1;
      end
    end
  end

`ifdef SCOREBOARD_FORWARDING_EN
  // Only younger (non-writeback) producers stall; a lone match in writeback
  // is satisfied from the writeback bus. A younger match wins because its
  // value is the newer one and is not on the bus yet.
  assign rx_hz = |(rx_hit & ~WB_MASK);
  assign ry_hz = |(ry_hit & ~WB_MASK);
  assign sb.fwd_rx = issue_w & |(rx_hit & WB_MASK) & ~rx_hz;
  assign sb.fwd_ry = issue_w & |(ry_hit & WB_MASK) & ~ry_hz;
`else
  assign rx_hz = |rx_hit;
  assign ry_hz = |ry_hit;
  assign sb.fwd_rx = 1'b0;
  assign sb.fwd_ry = 1'b0;
`endif

  assign stall_w = sb.dec_valid & (rx_hz | ry_hz | (|flag_hit) | (|mem_hit));
  assign issue_w = sb.dec_valid & ~stall_w & ~sb.flush;

  assign sb.stall          = stall_w;
  assign sb.issue          = issue_w;
  assign sb.pending_regs   = pend;
  assign sb.inflight_count = inflight;
  assign sb.stall_count    = stall_cnt;

  // NOTE: the queue is reset along with the counter because its valid bits
  // are control state; a stale valid entry after reset would raise a hazard.
  // NOTE: sequential state uses non-blocking assignments so every position
  // shifts from the pre-edge value of its neighbour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WB_LAT; i++) q[i] <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue_w) begin
        q[0] <= '{valid:   1'b1,
                  wr_en:   sb.dec_wr_en,
                  wr_reg:  sb.dec_wr_reg,
                  flag_wr: sb.dec_flag_wr,
                  mem_wr:  sb.dec_mem_wr};
      end else begin
        q[0] <= '0;
      end
      // Flush kills everything older than decode except the writeback entry,
      // which leaves the queue at this edge anyway.
      for (int i = 1; i < WB_LAT; i++) q[i] <= sb.flush ? '0 : q[i-1];
      if (sb.dec_valid && stall_w && !sb.flush && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed bench for pipeline_scoreboard (NUM_REGS=8, WB_LAT=2, CNT_W=4).
// Inputs change just after the falling edge; outputs are checked 1 ns later,
// well before the next rising edge. Forwarding-dependent expectations follow
// SCOREBOARD_FORWARDING_EN.
module tb_pipeline_scoreboard;
`ifdef SCOREBOARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  pipeline_scoreboard_if #(.NUM_REGS(8), .WB_LAT(2), .CNT_W(4)) sb_if ();

  pipeline_scoreboard #(.NUM_REGS(8), .WB_LAT(2), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    sb_if.dec_valid   = 1'b0;
    sb_if.dec_rx      = '0;
    sb_if.dec_ry      = '0;
    sb_if.dec_rx_rd   = 1'b0;
    sb_if.dec_ry_rd   = 1'b0;
    sb_if.dec_wr_en   = 1'b0;
    sb_if.dec_wr_reg  = '0;
    sb_if.dec_flag_rd = 1'b0;
    sb_if.dec_flag_wr = 1'b0;
    sb_if.dec_mem_rd  = 1'b0;
    sb_if.dec_mem_wr  = 1'b0;
    sb_if.flush       = 1'b0;
  endtask

  task automatic new_cycle();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic do_reset();
    new_cycle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic idle_op();
    new_cycle();
    #1;
  endtask

  task automatic wr_op(input logic [2:0] r);
    new_cycle();
    sb_if.dec_valid  = 1'b1;
    sb_if.dec_wr_en  = 1'b1;
    sb_if.dec_wr_reg = r;
    #1;
  endtask

  task automatic rd_op(input logic [2:0] rx, input logic [2:0] ry,
                       input logic rx_rd, input logic ry_rd, input logic fl);
    new_cycle();
    sb_if.dec_valid = 1'b1;
    sb_if.dec_rx    = rx;
    sb_if.dec_ry    = ry;
    sb_if.dec_rx_rd = rx_rd;
    sb_if.dec_ry_rd = ry_rd;
    sb_if.flush     = fl;
    #1;
  endtask

  task automatic flag_op(input logic wr, input logic rd);
    new_cycle();
    sb_if.dec_valid   = 1'b1;
    sb_if.dec_flag_wr = wr;
    sb_if.dec_flag_rd = rd;
    #1;
  endtask

  task automatic mem_op(input logic wr, input logic rd);
    new_cycle();
    sb_if.dec_valid  = 1'b1;
    sb_if.dec_mem_wr = wr;
    sb_if.dec_mem_rd = rd;
    #1;
  endtask

  // Compare writing R7 and NZ, followed by a flag-reading branch held until it
  // issues: two stalled cycles per round.
  task automatic cmp_branch_round();
    new_cycle();
    sb_if.dec_valid   = 1'b1;
    sb_if.dec_wr_en   = 1'b1;
    sb_if.dec_wr_reg  = 3'd7;
    sb_if.dec_flag_wr = 1'b1;
    #1;
    flag_op(1'b0, 1'b1);
    flag_op(1'b0, 1'b1);
    flag_op(1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();

    // Reset state with a valid, hazard-free-by-reset instruction presented.
    @(negedge clk);
    sb_if.dec_valid   = 1'b1;
    sb_if.dec_rx      = 3'd3;
    sb_if.dec_rx_rd   = 1'b1;
    sb_if.dec_flag_rd = 1'b1;
    sb_if.dec_mem_rd  = 1'b1;
    #1;
    check("rst.stall", sb_if.stall, 0);
    check("rst.issue", sb_if.issue, 1);
    check("rst.pending", sb_if.pending_regs, 8'h00);
    check("rst.inflight", sb_if.inflight_count, 0);
    check("rst.stall_count", sb_if.stall_count, 0);
    check("rst.fwd_rx", sb_if.fwd_rx, 0);
    new_cycle();
    reset = 1'b0;

    // RAW on R3: writer at t, reader at t+1.
    wr_op(3'd3);
    check("raw.t.issue", sb_if.issue, 1);
    check("raw.t.stall", sb_if.stall, 0);
    rd_op(3'd3, 3'd5, 1'b1, 1'b1, 1'b0);
    check("raw.t1.stall", sb_if.stall, 1);
    check("raw.t1.issue", sb_if.issue, 0);
    check("raw.t1.pending", sb_if.pending_regs, 8'h08);
    check("raw.t1.inflight", sb_if.inflight_count, 1);
    rd_op(3'd3, 3'd5, 1'b1, 1'b1, 1'b0);
    check("raw.t2.stall", sb_if.stall, FWD ? 0 : 1);
    check("raw.t2.issue", sb_if.issue, FWD ? 1 : 0);
    check("raw.t2.fwd_rx", sb_if.fwd_rx, FWD ? 1 : 0);
    check("raw.t2.fwd_ry", sb_if.fwd_ry, 0);
    check("raw.t2.inflight", sb_if.inflight_count, 1);
    rd_op(3'd3, 3'd5, 1'b1, 1'b1, 1'b0);
    check("raw.t3.stall", sb_if.stall, 0);
    check("raw.t3.issue", sb_if.issue, 1);
    check("raw.t3.fwd_rx", sb_if.fwd_rx, 0);
    check("raw.t3.pending", sb_if.pending_regs, 8'h00);
    check("raw.t3.stall_count", sb_if.stall_count, FWD ? 1 : 2);

    // WAW on R3 is not a hazard; a younger writer blocks forwarding.
    do_reset();
    wr_op(3'd3);
    wr_op(3'd3);
    check("waw.stall", sb_if.stall, 0);
    check("waw.issue", sb_if.issue, 1);
    rd_op(3'd3, 3'd0, 1'b1, 1'b0, 1'b0);
    check("waw.rd1.stall", sb_if.stall, 1);
    check("waw.rd1.fwd_rx", sb_if.fwd_rx, 0);
    check("waw.rd1.pending", sb_if.pending_regs, 8'h08);
    check("waw.rd1.inflight", sb_if.inflight_count, 2);
    rd_op(3'd3, 3'd0, 1'b1, 1'b0, 1'b0);
    check("waw.rd2.stall", sb_if.stall, FWD ? 0 : 1);
    check("waw.rd2.fwd_rx", sb_if.fwd_rx, FWD ? 1 : 0);
    check("waw.rd2.pending", sb_if.pending_regs, 8'h08);
    idle_op();
    check("waw.end.pending", sb_if.pending_regs, 8'h00);

    // Independent back-to-back ops.
    do_reset();
    wr_op(3'd1);
    rd_op(3'd2, 3'd4, 1'b1, 1'b1, 1'b0);
    check("ind.t1.stall", sb_if.stall, 0);
    check("ind.t1.issue", sb_if.issue, 1);
    check("ind.t1.pending", sb_if.pending_regs, 8'h02);
    idle_op();
    check("ind.t2.pending", sb_if.pending_regs, 8'h02);
    check("ind.t2.inflight", sb_if.inflight_count, 2);
    idle_op();
    check("ind.t3.pending", sb_if.pending_regs, 8'h00);
    check("ind.t3.inflight", sb_if.inflight_count, 1);

    // Flag and memory hazards.
    do_reset();
    flag_op(1'b1, 1'b0);
    flag_op(1'b0, 1'b1);
    check("flag.t1.stall", sb_if.stall, 1);
    flag_op(1'b0, 1'b1);
    check("flag.t2.stall", sb_if.stall, 1);
    flag_op(1'b0, 1'b1);
    check("flag.t3.issue", sb_if.issue, 1);
    check("flag.t3.stall_count", sb_if.stall_count, 2);
    mem_op(1'b1, 1'b0);
    mem_op(1'b0, 1'b1);
    check("st_ld.t1.stall", sb_if.stall, 1);
    mem_op(1'b0, 1'b1);
    check("st_ld.t2.stall", sb_if.stall, 1);
    mem_op(1'b0, 1'b1);
    check("st_ld.t3.issue", sb_if.issue, 1);
    check("st_ld.t3.stall_count", sb_if.stall_count, 4);
    mem_op(1'b0, 1'b1);
    mem_op(1'b1, 1'b0);
    check("ld_st.stall", sb_if.stall, 0);
    check("ld_st.issue", sb_if.issue, 1);

    // Flush squashes the R5 writer; flush cycle is not counted as a stall.
    do_reset();
    wr_op(3'd5);
    rd_op(3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    check("flush.t1.issue", sb_if.issue, 0);
    rd_op(3'd5, 3'd0, 1'b1, 1'b0, 1'b0);
    check("flush.t2.stall", sb_if.stall, 0);
    check("flush.t2.issue", sb_if.issue, 1);
    check("flush.t2.pending", sb_if.pending_regs, 8'h00);
    check("flush.t2.inflight", sb_if.inflight_count, 0);
    wr_op(3'd6);
    rd_op(3'd6, 3'd0, 1'b1, 1'b0, 1'b1);
    check("flush_st.stall", sb_if.stall, 1);
    check("flush_st.issue", sb_if.issue, 0);
    rd_op(3'd6, 3'd0, 1'b1, 1'b0, 1'b0);
    check("flush_st.after.stall", sb_if.stall, 0);
    check("flush_st.after.count", sb_if.stall_count, 0);

    // Reset pulsed while stalled with stall_count = 7.
    do_reset();
    for (int k = 0; k < 3; k++) cmp_branch_round();
    new_cycle();
    sb_if.dec_valid   = 1'b1;
    sb_if.dec_wr_en   = 1'b1;
    sb_if.dec_wr_reg  = 3'd7;
    sb_if.dec_flag_wr = 1'b1;
    #1;
    flag_op(1'b0, 1'b1);
    flag_op(1'b0, 1'b1);
    check("midrst.pre.stall", sb_if.stall, 1);
    check("midrst.pre.count", sb_if.stall_count, 7);
    check("midrst.pre.pending", sb_if.pending_regs, 8'h80);
    reset = 1'b1;
    #1;
    check("midrst.stall", sb_if.stall, 0);
    check("midrst.issue", sb_if.issue, 1);
    check("midrst.count", sb_if.stall_count, 0);
    check("midrst.pending", sb_if.pending_regs, 8'h00);
    check("midrst.inflight", sb_if.inflight_count, 0);
    new_cycle();
    reset = 1'b0;

    // Saturation of the 4-bit stall counter over 2^4+3 or more stall cycles.
    do_reset();
    for (int k = 0; k < 7; k++) cmp_branch_round();
    check("sat.14", sb_if.stall_count, 14);
    cmp_branch_round();
    check("sat.15", sb_if.stall_count, 15);
    for (int k = 0; k < 2; k++) cmp_branch_round();
    check("sat.hold", sb_if.stall_count, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_scoreboard.md
Name: pipeline_scoreboard

Overview:
- Parametrised hazard/scoreboard unit for the in-order CPU pipeline, sitting between decode and execute.
- Tracks every issued instruction until writeback, and stalls decode on RAW hazards against registers, NZ flags and memory (load after store).
- Generalises the fixed 4-stage, 8-register hold logic to any register count and issue-to-writeback latency.
- Adds flush, an in-flight/pending-register view, a stall counter, and optional writeback forwarding.

Parameters:
- NUM_REGS, 8: architectural registers; REG_W = $clog2(NUM_REGS) is a localparam.
- WB_LAT, 2: cycles from issue to writeback, ≥1. The entry at position WB_LAT-1 is in writeback.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- dec_valid  in  1  decode stage holds a valid instruction
- dec_rx, dec_ry  in  REG_W each  source register indices
- dec_rx_rd, dec_ry_rd  in  1 each  source actually read
- dec_wr_en  in  1  instruction writes a register
- dec_wr_reg  in  REG_W  destination register
- dec_flag_rd / dec_flag_wr  in  1  reads / writes NZ
- dec_mem_rd / dec_mem_wr  in  1  load / store
- flush  in  1  squash younger in-flight work (taken branch)
- stall  out  1  hold decode and PC
- issue  out  1  dec_valid & ~stall & ~flush
- fwd_rx, fwd_ry  out  1 each  source to be taken from the writeback bus
- pending_regs  out  NUM_REGS  bit r set if a write to r is in flight
- inflight_count  out  $clog2(WB_LAT+1)  number of valid entries
- stall_count  out  CNT_W  cycles with dec_valid & stall, saturating

Behaviour:
- In-flight queue: WB_LAT-entry shift register. Each entry holds {valid, wr_en, wr_reg, flag_wr, mem_wr}.
  - Every clock: position 0 <= issued instruction if issue, else invalid.
  - Position i <= position i-1; position WB_LAT-1 retires.
- Hazards are evaluated combinationally against all valid entries. All outputs except stall_count are combinational.
  - Register hazard: dec_rx_rd and a valid entry with wr_en and wr_reg == dec_rx (same for ry).
  - Flag hazard: dec_flag_rd and any valid entry with flag_wr.
  - Memory hazard: dec_mem_rd and any valid entry with mem_wr.
- stall = dec_valid & (any hazard). There is no extra hold cycle: stall drops in the cycle the last conflicting entry retires.
- Timing: a writer issued at t and a dependent reader at t+1 give stall at t+1..t+WB_LAT, and the reader issues at t+WB_LAT+1.
- WAW is not a hazard (in-order, fixed latency). Several in-flight writers to the same register keep that bit set until the youngest retires.
- pending_regs is the OR of the one-hot wr_reg of all valid wr_en entries.
- flush:
  - Invalidates positions 0..WB_LAT-2 at the next clock.
  - The entry in writeback (WB_LAT-1) still retires normally.
  - The decode instruction is not issued in the flush cycle.
  - With WB_LAT = 1, flush only blocks issue.
- Simultaneous retire and issue in the same cycle is normal shifting. An instruction never hazards against itself.
- stall_count increments when dec_valid & stall and holds at 2^CNT_W-1. The stall count is excluded in the flush cycle.
- Reset (any time, including mid-stall): all entries invalid, stall_count = 0. Consequently stall = 0, issue = dec_valid, pending_regs = 0, inflight_count = 0, fwd_* = 0.
- dec_* inputs are ignored when dec_valid = 0.

Optional Feature:
- Macro SCOREBOARD_FORWARDING_EN.
- When defined:
  - A register hazard against the entry at position WB_LAT-1 only does not stall.
  - fwd_rx/fwd_ry assert for the corresponding source when issue = 1.
  - If a younger entry also matches that register, the hazard still stalls and fwd is 0.
  - Flag and memory hazards are unaffected.
- When undefined: fwd_rx = fwd_ry = 0 always, and the WB entry stalls like any other.

Test Plan:
- WB_LAT=2: issue wr R3 at t, reader dec_rx=3 (rx_rd=1) at t+1 → stall=1 at t+1,t+2; issue=1 at t+3; stall_count=2.
- Same sequence with SCOREBOARD_FORWARDING_EN → stall only at t+1; issue at t+2 with fwd_rx=1, fwd_ry=0.
- Back-to-back independent ops (wr R1, then read R2/R4) → stall never asserts. pending_regs=8'b0000_0010 during t+1..t+2, then 0.
- cmp (flag_wr) then conditional branch (flag_rd) next cycle → 2 stall cycles. Store then load → 2 stall cycles. Load then store → 0.
- Writer R5 issued at t, flush at t+1 → at t+2 pending_regs=0, a reader of R5 presented at t+2 issues with no stall, inflight_count=0.
- Reset pulsed while stalled with stall_count=7 → stall=0, stall_count=0, pending_regs=0 immediately. Forced stall for 2^CNT_W+3 cycles → stall_count holds at all-ones.
